// File: rtl/prog_loader.sv
// prog_loader: fills instruction memory from a byte stream while holding the CPU in reset
module prog_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, CHECK, DATA, WRITE, DONE, ERR} state_t;
    state_t state, state_nx;
    logic [15:0]   n;
    logic [ADDR_W:0] widx, widx_inc;
    logic [1:0]    bidx;
    logic [31:0]   word;
    logic          xfer, bad, last;
    // Word index is one bit wider than the address so that N==DEPTH terminates cleanly.
    assign widx_inc = widx + (ADDR_W+1)'(1);
    assign bad      = (n == 16'd0) || (32'(n) > 32'(DEPTH));
    assign last     = widx_inc == (ADDR_W+1)'(n);
    assign xfer     = in_valid && in_ready;
    assign im_addr  = widx[ADDR_W-1:0];
    assign im_wdata = word;
    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end
    // Next-state and state-decoded outputs; nothing here depends combinationally on in_data.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        im_we     = 1'b0;
        cpu_rst_n = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE:   state_nx = start ? HDR_HI : IDLE;
            HDR_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                state_nx = in_valid ? HDR_LO : HDR_HI;
            end
            HDR_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                state_nx = in_valid ? CHECK : HDR_LO;
            end
            CHECK: begin
                busy     = 1'b1;
                state_nx = bad ? ERR : DATA;
            end
            DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                state_nx = (in_valid && bidx == 2'd3) ? WRITE : DATA;
            end
            WRITE: begin
                im_we    = 1'b1;
                busy     = 1'b1;
                state_nx = last ? DONE : DATA;
            end
            DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
                state_nx  = start ? HDR_HI : DONE;
            end
            ERR: begin
                err      = 1'b1;
                state_nx = start ? HDR_HI : ERR;
            end
            default: state_nx = IDLE;
        endcase
    end
    // Header latch, word/byte indices and big-endian word assembly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            n    <= '0;
            widx <= '0;
            bidx <= '0;
            word <= '0;
        end else begin
            if (state == HDR_HI && xfer) n[15:8] <= in_data;
            if (state == HDR_LO && xfer) n[7:0] <= in_data;
            if (state == CHECK) begin
                widx <= '0;
                bidx <= '0;
            end
            if (state == DATA && xfer) begin
                word <= {word[23:0], in_data};
                bidx <= bidx + 2'd1;
            end
            if (state == WRITE) widx <= widx_inc;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed checks of the stream loader against hand-computed writes and timing
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, im_we, cpu_rst_n, busy, done, err;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    int          nchk = 0, nerr = 0, cyc = 0, t0;
    logic [9:0]  wa[$];
    logic [31:0] wd[$];

    prog_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Cycle counter and write capture (a write lands only when reset is not asserted).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && im_we) begin
            wa.push_back(im_addr);
            wd.push_back(im_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int k = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        chk("send_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'hxx;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send(w[8*i +: 8], gap);
    endtask

    task automatic wait_flag(input string tag, input bit want_err);
        int k = 0;
        while (!(want_err ? err : done) && k < 50) begin
            tick();
            k++;
        end
        chk(tag, {63'd0, want_err ? err : done}, 64'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_we"}, {63'd0, im_we}, 64'd0);
        chk({tag, "_addr"}, {54'd0, im_addr}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, im_wdata}, 64'd0);
        chk({tag, "_cpurst"}, {63'd0, cpu_rst_n}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_err"}, {63'd0, err}, 64'd0);
    endtask

    initial begin
        int bad_cnt;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) tick();
        chk_reset_outs("reset");
        rst = 1'b1;
        tick();
        chk("idle_ready", {63'd0, in_ready}, 64'd0);

        // Normal two-word load with continuous valid.
        do_start();
        chk("start_ready", {63'd0, in_ready}, 64'd1);
        chk("start_busy", {63'd0, busy}, 64'd1);
        t0 = cyc;
        send(8'h00, 0); send(8'h02, 0);
        send_word(32'h12345678, 0);
        send_word(32'hDEADBEEF, 0);
        wait_flag("norm_done", 1'b0);
        chk("norm_latency", 64'(cyc - t0), 64'd13);
        chk("norm_cpurst", {63'd0, cpu_rst_n}, 64'd1);
        chk("norm_busy", {63'd0, busy}, 64'd0);
        chk("norm_ready", {63'd0, in_ready}, 64'd0);
        chk("norm_nw", 64'(wa.size()), 64'd2);
        chk("norm_a0", {54'd0, wa[0]}, 64'd0);
        chk("norm_d0", {32'd0, wd[0]}, 64'h12345678);
        chk("norm_a1", {54'd0, wa[1]}, 64'd1);
        chk("norm_d1", {32'd0, wd[1]}, 64'hDEADBEEF);
        wa.delete(); wd.delete();

        // Bad header: N==0, then N>DEPTH.
        do_start();
        chk("rs_done_cpurst", {63'd0, cpu_rst_n}, 64'd0);
        chk("rs_done_done", {63'd0, done}, 64'd0);
        send(8'h00, 0); send(8'h00, 0);
        wait_flag("zero_err", 1'b1);
        chk("zero_cpurst", {63'd0, cpu_rst_n}, 64'd0);
        chk("zero_ready", {63'd0, in_ready}, 64'd0);
        do_start();
        chk("err_clear", {63'd0, err}, 64'd0);
        send(8'h04, 0); send(8'h01, 0);
        wait_flag("big_err", 1'b1);
        chk("big_cpurst", {63'd0, cpu_rst_n}, 64'd0);
        chk("bad_nw", 64'(wa.size()), 64'd0);

        // Backpressure: three idle cycles between every byte.
        do_start();
        send(8'h00, 3); send(8'h02, 3);
        send_word(32'h12345678, 3);
        send_word(32'hDEADBEEF, 3);
        wait_flag("bp_done", 1'b0);
        chk("bp_nw", 64'(wa.size()), 64'd2);
        chk("bp_d0", {32'd0, wd[0]}, 64'h12345678);
        chk("bp_a1", {54'd0, wa[1]}, 64'd1);
        chk("bp_d1", {32'd0, wd[1]}, 64'hDEADBEEF);
        wa.delete(); wd.delete();

        // Reset partway through the second word, then a clean one-word load.
        do_start();
        send(8'h00, 0); send(8'h02, 0);
        send_word(32'hA1B2C3D4, 0);
        send(8'h55, 0); send(8'h66, 0);
        rst = 1'b0;
        tick();
        chk_reset_outs("midrst");
        rst = 1'b1;
        tick();
        chk("midrst_nw", 64'(wa.size()), 64'd1);
        wa.delete(); wd.delete();
        do_start();
        send(8'h00, 0); send(8'h01, 0);
        send_word(32'hCAFEBABE, 0);
        wait_flag("post_done", 1'b0);
        chk("post_d0", {32'd0, wd[0]}, 64'hCAFEBABE);
        wa.delete(); wd.delete();

        // Restart from DONE overwrites address 0.
        do_start();
        chk("restart_cpurst", {63'd0, cpu_rst_n}, 64'd0);
        chk("restart_done", {63'd0, done}, 64'd0);
        send(8'h00, 0); send(8'h01, 0);
        send_word(32'h11223344, 0);
        wait_flag("restart_done2", 1'b0);
        chk("restart_nw", 64'(wa.size()), 64'd1);
        chk("restart_a0", {54'd0, wa[0]}, 64'd0);
        chk("restart_d0", {32'd0, wd[0]}, 64'h11223344);
        wa.delete(); wd.delete();

        // Maximum image: N == DEPTH.
        do_start();
        send(8'h04, 0); send(8'h00, 0);
        for (int i = 0; i < 1024; i++) send_word({16'(i) ^ 16'h5A5A, 16'(i)}, 0);
        wait_flag("max_done", 1'b0);
        chk("max_nw", 64'(wa.size()), 64'd1024);
        bad_cnt = 0;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] !== 10'(i) || wd[i] !== {16'(i) ^ 16'h5A5A, 16'(i)}) bad_cnt++;
        chk("max_contents", 64'(bad_cnt), 64'd0);
        chk("max_last_a", {54'd0, wa[wa.size()-1]}, 64'd1023);
        in_valid = 1'b1; in_data = 8'h77;
        repeat (3) tick();
        chk("max_no_extra_ready", {63'd0, in_ready}, 64'd0);
        chk("max_still_done", {63'd0, done}, 64'd1);
        chk("max_nw_after", 64'(wa.size()), 64'd1024);
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
